// File: rtl/reg_file_pkg.sv
// Shared definitions for the multi-port register file.
//   DEF_DATA_W / DEF_ADDR_W : default register width and address width
//   data_t / addr_t         : register word and register address at the defaults
//   slice_lo()              : low bit of port k inside a packed multi-port bus
package reg_file_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 5;

  typedef logic [DEF_DATA_W-1:0] data_t;
  typedef logic [DEF_ADDR_W-1:0] addr_t;

  function automatic int slice_lo(input int port, input int width);
    return port * width;
  endfunction

endpackage

// File: rtl/rf_read_port.sv
// One combinational read port of reg_file_mp.
//   addr     in  : register address being read
//   regs     in  : view of the storage array
//   busy_vec in  : registered scoreboard
//   wr_en    in  : per-port write enables (already gated off during reset)
//   wr_addr  in  : packed write addresses
//   wr_data  in  : packed write data
//   rd_data  out : stored value, bypassed write data, or 0 for r0
//   rd_busy  out : scoreboard bit, cleared by a same-cycle bypassed write or for r0
module rf_read_port
  import reg_file_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int NUM_WR   = 2,
  parameter int BYPASS   = 1,
  parameter int ZERO_REG = 1
) (
  input  logic [ADDR_W-1:0]        addr,
  input  logic [DATA_W-1:0]        regs [2**ADDR_W],
  input  logic [2**ADDR_W-1:0]     busy_vec,
  input  logic [NUM_WR-1:0]        wr_en,
  input  logic [NUM_WR*ADDR_W-1:0] wr_addr,
  input  logic [NUM_WR*DATA_W-1:0] wr_data,
  output logic [DATA_W-1:0]        rd_data,
  output logic                     rd_busy
);

  // Stored data is the default so no path can leave the output undriven;
  // ascending port order lets the highest-index matching writer win.
  always_comb begin
    rd_data = regs[addr];
    rd_busy = busy_vec[addr];
    if (BYPASS != 0) begin
      for (int k = 0; k < NUM_WR; k++) begin
        if (wr_en[k] && (wr_addr[slice_lo(k, ADDR_W) +: ADDR_W] == addr)) begin
          rd_data = wr_data[slice_lo(k, DATA_W) +: DATA_W];
          rd_busy = 1'b0;
        end
      end
    end
    if ((ZERO_REG != 0) && (addr == '0)) begin
      rd_data = '0;
      rd_busy = 1'b0;
    end
  end

endmodule

// File: rtl/reg_file_mp.sv
// Multi-port register file with a busy-bit scoreboard for RAW hazard stalls.
//   clk        in  : clock, rising edge
//   rstn       in  : asynchronous active-low reset (clears registers and scoreboard)
//   rd_addr    in  : NUM_RD packed read addresses
//   rd_data    out : NUM_RD packed read data (combinational)
//   rd_busy    out : per read port scoreboard bit (combinational)
//   wr_en      in  : per write port enable
//   wr_addr    in  : NUM_WR packed write addresses
//   wr_data    in  : NUM_WR packed write data
//   claim_en   in  : mark claim_addr busy at the next edge
//   claim_addr in  : destination register being claimed
//   busy_vec   out : full registered scoreboard
module reg_file_mp
  import reg_file_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int NUM_RD   = 2,
  parameter int NUM_WR   = 2,
  parameter int BYPASS   = 1,
  parameter int ZERO_REG = 1
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_busy,
  input  logic [NUM_WR-1:0]        wr_en,
  input  logic [NUM_WR*ADDR_W-1:0] wr_addr,
  input  logic [NUM_WR*DATA_W-1:0] wr_data,
  input  logic                     claim_en,
  input  logic [ADDR_W-1:0]        claim_addr,
  output logic [2**ADDR_W-1:0]     busy_vec
);

  localparam int DEPTH = 2**ADDR_W;

  logic [DATA_W-1:0] regs [DEPTH];
  logic [DEPTH-1:0]  busy_q;
  logic [NUM_WR-1:0] wr_en_live;

  // Writes are ignored during reset, so they must not leak through the bypass either.
  assign wr_en_live = rstn ? wr_en : '0;
  assign busy_vec   = busy_q;

  // Later non-blocking assignments take effect: the highest write port wins
  // a same-address conflict, and a claim overrides a write's busy clear.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs[i] <= '0;
      end
      busy_q <= '0;
    end else begin
      for (int k = 0; k < NUM_WR; k++) begin
        if (wr_en[k] &&
            !((ZERO_REG != 0) && (wr_addr[slice_lo(k, ADDR_W) +: ADDR_W] == '0))) begin
          regs[wr_addr[slice_lo(k, ADDR_W) +: ADDR_W]]   <= wr_data[slice_lo(k, DATA_W) +: DATA_W];
          busy_q[wr_addr[slice_lo(k, ADDR_W) +: ADDR_W]] <= 1'b0;
        end
      end
      if (claim_en && !((ZERO_REG != 0) && (claim_addr == '0))) begin
        busy_q[claim_addr] <= 1'b1;
      end
    end
  end

  for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
    rf_read_port #(
      .DATA_W   (DATA_W),
      .ADDR_W   (ADDR_W),
      .NUM_WR   (NUM_WR),
      .BYPASS   (BYPASS),
      .ZERO_REG (ZERO_REG)
    ) u_rd (
      .addr     (rd_addr[slice_lo(p, ADDR_W) +: ADDR_W]),
      .regs     (regs),
      .busy_vec (busy_q),
      .wr_en    (wr_en_live),
      .wr_addr  (wr_addr),
      .wr_data  (wr_data),
      .rd_data  (rd_data[slice_lo(p, DATA_W) +: DATA_W]),
      .rd_busy  (rd_busy[p])
    );
  end

endmodule

// File: tb/tb_reg_file_mp.sv
// Directed bench for reg_file_mp: a bypassing instance and a non-bypassing
// instance share all inputs, so their views of the same state can be compared.
module tb_reg_file_mp;
  import reg_file_pkg::*;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int NR = 2;
  localparam int NW = 2;

  logic              clk = 1'b0;
  logic              rstn;
  logic [NR*AW-1:0]  rd_addr;
  logic [NR*DW-1:0]  rd_data, rd_data_nb;
  logic [NR-1:0]     rd_busy, rd_busy_nb;
  logic [NW-1:0]     wr_en;
  logic [NW*AW-1:0]  wr_addr;
  logic [NW*DW-1:0]  wr_data;
  logic              claim_en;
  logic [AW-1:0]     claim_addr;
  logic [2**AW-1:0]  busy_vec, busy_vec_nb;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  reg_file_mp #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .NUM_WR(NW), .BYPASS(1), .ZERO_REG(1)) dut (
    .clk(clk), .rstn(rstn), .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .claim_en(claim_en),
    .claim_addr(claim_addr), .busy_vec(busy_vec)
  );

  reg_file_mp #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .NUM_WR(NW), .BYPASS(0), .ZERO_REG(1)) dut_nb (
    .clk(clk), .rstn(rstn), .rd_addr(rd_addr), .rd_data(rd_data_nb), .rd_busy(rd_busy_nb),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .claim_en(claim_en),
    .claim_addr(claim_addr), .busy_vec(busy_vec_nb)
  );

  typedef struct {
    logic [1:0]  we;
    logic [4:0]  wa0, wa1;
    logic [31:0] wd0, wd1;
    logic        ce;
    logic [4:0]  ca;
    logic [4:0]  ra0, ra1;
    logic [31:0] e_rd0, e_rd1;
    logic        e_b0, e_b1;
    logic [31:0] e_bv;
  } vec_t;

  vec_t tbl [15];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [1:0] we, input logic [4:0] wa0, input logic [4:0] wa1,
                       input logic [31:0] wd0, input logic [31:0] wd1, input logic ce,
                       input logic [4:0] ca, input logic [4:0] ra0, input logic [4:0] ra1);
    wr_en      = we;
    wr_addr    = {wa1, wa0};
    wr_data    = {wd1, wd0};
    claim_en   = ce;
    claim_addr = ca;
    rd_addr    = {ra1, ra0};
  endtask

  task automatic idle(input logic [4:0] ra0, input logic [4:0] ra1);
    drive(2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 1'b0, 5'd0, ra0, ra1);
  endtask

  logic [31:0] mref [32];
  logic [31:0] bref;

  initial begin
    //            we     wa0    wa1    wd0           wd1           ce    ca     ra0    ra1    e_rd0         e_rd1         b0    b1    bv
    tbl[0]  = '{2'b11, 5'd5,  5'd5,  32'h1111,     32'h2222,     1'b0, 5'd0,  5'd5,  5'd0,  32'h2222,     32'h0,        1'b0, 1'b0, 32'h0};
    tbl[1]  = '{2'b00, 5'd0,  5'd0,  32'h0,        32'h0,        1'b0, 5'd0,  5'd5,  5'd5,  32'h2222,     32'h2222,     1'b0, 1'b0, 32'h0};
    tbl[2]  = '{2'b00, 5'd0,  5'd0,  32'h0,        32'h0,        1'b1, 5'd3,  5'd3,  5'd5,  32'h0,        32'h2222,     1'b0, 1'b0, 32'h0};
    tbl[3]  = '{2'b00, 5'd0,  5'd0,  32'h0,        32'h0,        1'b0, 5'd0,  5'd3,  5'd5,  32'h0,        32'h2222,     1'b1, 1'b0, 32'h8};
    tbl[4]  = '{2'b01, 5'd3,  5'd0,  32'hAAAA,     32'h0,        1'b0, 5'd0,  5'd3,  5'd3,  32'hAAAA,     32'hAAAA,     1'b0, 1'b0, 32'h8};
    tbl[5]  = '{2'b00, 5'd0,  5'd0,  32'h0,        32'h0,        1'b0, 5'd0,  5'd3,  5'd0,  32'hAAAA,     32'h0,        1'b0, 1'b0, 32'h0};
    tbl[6]  = '{2'b10, 5'd0,  5'd3,  32'h0,        32'hBBBB,     1'b1, 5'd3,  5'd3,  5'd5,  32'hBBBB,     32'h2222,     1'b0, 1'b0, 32'h0};
    tbl[7]  = '{2'b00, 5'd0,  5'd0,  32'h0,        32'h0,        1'b0, 5'd0,  5'd3,  5'd5,  32'hBBBB,     32'h2222,     1'b1, 1'b0, 32'h8};
    tbl[8]  = '{2'b01, 5'd0,  5'd0,  32'hFFFFFFFF, 32'h0,        1'b1, 5'd0,  5'd0,  5'd3,  32'h0,        32'hBBBB,     1'b0, 1'b1, 32'h8};
    tbl[9]  = '{2'b00, 5'd0,  5'd0,  32'h0,        32'h0,        1'b0, 5'd0,  5'd0,  5'd3,  32'h0,        32'hBBBB,     1'b0, 1'b1, 32'h8};
    tbl[10] = '{2'b10, 5'd0,  5'd7,  32'h0,        32'hDEADBEEF, 1'b0, 5'd0,  5'd7,  5'd7,  32'hDEADBEEF, 32'hDEADBEEF, 1'b0, 1'b0, 32'h8};
    tbl[11] = '{2'b11, 5'd9,  5'd3,  32'h12345678, 32'hCAFEF00D, 1'b1, 5'd9,  5'd9,  5'd3,  32'h12345678, 32'hCAFEF00D, 1'b0, 1'b0, 32'h8};
    tbl[12] = '{2'b00, 5'd0,  5'd0,  32'h0,        32'h0,        1'b0, 5'd0,  5'd9,  5'd3,  32'h12345678, 32'hCAFEF00D, 1'b1, 1'b0, 32'h200};
    tbl[13] = '{2'b11, 5'd1,  5'd9,  32'h55,       32'h99,       1'b0, 5'd0,  5'd9,  5'd1,  32'h99,       32'h55,       1'b0, 1'b0, 32'h200};
    tbl[14] = '{2'b00, 5'd0,  5'd0,  32'h0,        32'h0,        1'b0, 5'd0,  5'd9,  5'd1,  32'h99,       32'h55,       1'b0, 1'b0, 32'h0};

    // Power-up reset with a real falling edge on rstn.
    rstn = 1'b1;
    idle(5'd5, 5'd7);
    #2 rstn = 1'b0;
    #1;
    chk("reset rd_data",  {32'h0, rd_data},  64'h0);
    chk("reset rd_busy",  {62'h0, rd_busy},  64'h0);
    chk("reset busy_vec", {32'h0, busy_vec}, 64'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rstn = 1'b1;

    // Table-driven directed vectors on the bypassing instance.
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      drive(tbl[i].we, tbl[i].wa0, tbl[i].wa1, tbl[i].wd0, tbl[i].wd1,
            tbl[i].ce, tbl[i].ca, tbl[i].ra0, tbl[i].ra1);
      #1;
      chk($sformatf("v%0d rd0", i),      {32'h0, rd_data[31:0]},  {32'h0, tbl[i].e_rd0});
      chk($sformatf("v%0d rd1", i),      {32'h0, rd_data[63:32]}, {32'h0, tbl[i].e_rd1});
      chk($sformatf("v%0d busy0", i),    {63'h0, rd_busy[0]},     {63'h0, tbl[i].e_b0});
      chk($sformatf("v%0d busy1", i),    {63'h0, rd_busy[1]},     {63'h0, tbl[i].e_b1});
      chk($sformatf("v%0d busy_vec", i), {32'h0, busy_vec},       {32'h0, tbl[i].e_bv});
    end

    // No bypass: the non-bypassing instance shows the old value until the edge.
    @(negedge clk);
    drive(2'b01, 5'd7, 5'd0, 32'h0BADF00D, 32'h0, 1'b0, 5'd0, 5'd7, 5'd7);
    #1;
    chk("bypass new r7",   {32'h0, rd_data[31:0]},    {32'h0, 32'h0BADF00D});
    chk("nobypass old r7", {32'h0, rd_data_nb[31:0]}, {32'h0, 32'hDEADBEEF});
    @(negedge clk);
    idle(5'd7, 5'd7);
    #1;
    chk("nobypass next r7", {32'h0, rd_data_nb[31:0]}, {32'h0, 32'h0BADF00D});

    // Busy masking only with bypass: claim r4, then write it while reading it.
    @(negedge clk);
    drive(2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 1'b1, 5'd4, 5'd4, 5'd4);
    @(negedge clk);
    drive(2'b10, 5'd0, 5'd4, 32'h0, 32'h44, 1'b0, 5'd0, 5'd4, 5'd4);
    #1;
    chk("bypass busy r4",      {63'h0, rd_busy[0]},       64'h0);
    chk("bypass data r4",      {32'h0, rd_data[31:0]},    64'h44);
    chk("nobypass busy r4",    {63'h0, rd_busy_nb[0]},    64'h1);
    chk("nobypass data r4",    {32'h0, rd_data_nb[31:0]}, 64'h0);
    chk("nobypass busy_vec",   {32'h0, busy_vec_nb},      64'h10);
    @(negedge clk);
    idle(5'd4, 5'd4);
    #1;
    chk("nobypass r4 after",   {32'h0, rd_data_nb[31:0]}, 64'h44);
    chk("nobypass busy after", {63'h0, rd_busy_nb[0]},    64'h0);

    // Mid-run reset with a write and claim pending in the same cycle.
    @(negedge clk);
    drive(2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 1'b1, 5'd6, 5'd5, 5'd7);
    @(negedge clk);
    drive(2'b01, 5'd5, 5'd0, 32'h77777777, 32'h0, 1'b1, 5'd8, 5'd5, 5'd7);
    #1;
    chk("pre-reset busy_vec", {32'h0, busy_vec}, 64'h40);
    rstn = 1'b0;
    #1;
    chk("midreset rd_data",     {32'h0, rd_data},     64'h0);
    chk("midreset rd_data_nb",  {32'h0, rd_data_nb},  64'h0);
    chk("midreset busy_vec",    {32'h0, busy_vec},    64'h0);
    chk("midreset busy_vec_nb", {32'h0, busy_vec_nb}, 64'h0);
    @(posedge clk);
    @(negedge clk);
    idle(5'd5, 5'd8);
    rstn = 1'b1;
    #1;
    chk("post-reset rd r5", {32'h0, rd_data[31:0]}, 64'h0);
    chk("post-reset busy",  {32'h0, busy_vec},      64'h0);
    @(negedge clk);
    #1;
    chk("post-reset rd r5 later", {32'h0, rd_data_nb[31:0]}, 64'h0);

    // Randomised traffic against a small reference model, starting from reset state.
    for (int i = 0; i < 32; i++) mref[i] = 32'h0;
    bref = 32'h0;
    for (int c = 0; c < 300; c++) begin
      logic [1:0]  we;
      logic [4:0]  wa [2];
      logic [31:0] wd [2];
      logic        ce;
      logic [4:0]  ca;
      logic [4:0]  ra [2];
      logic [31:0] e_d, e_dnb;
      logic        e_b, e_bnb;
      @(negedge clk);
      we    = 2'($urandom_range(0, 3));
      wa[0] = 5'($urandom_range(0, 7));
      wa[1] = 5'($urandom_range(0, 7));
      wd[0] = $urandom;
      wd[1] = $urandom;
      ce    = 1'($urandom_range(0, 1));
      ca    = 5'($urandom_range(0, 7));
      ra[0] = 5'($urandom_range(0, 7));
      ra[1] = 5'($urandom_range(0, 7));
      drive(we, wa[0], wa[1], wd[0], wd[1], ce, ca, ra[0], ra[1]);
      #1;
      for (int p = 0; p < 2; p++) begin
        e_dnb = (ra[p] == 5'd0) ? 32'h0 : mref[ra[p]];
        e_bnb = (ra[p] == 5'd0) ? 1'b0  : bref[ra[p]];
        e_d   = e_dnb;
        e_b   = e_bnb;
        if (ra[p] != 5'd0) begin
          if (we[1] && wa[1] == ra[p]) begin
            e_d = wd[1];
            e_b = 1'b0;
          end else if (we[0] && wa[0] == ra[p]) begin
            e_d = wd[0];
            e_b = 1'b0;
          end
        end
        chk($sformatf("rnd%0d rd%0d", c, p),    {32'h0, rd_data[p*32 +: 32]},    {32'h0, e_d});
        chk($sformatf("rnd%0d busy%0d", c, p),  {63'h0, rd_busy[p]},             {63'h0, e_b});
        chk($sformatf("rnd%0d nbrd%0d", c, p),  {32'h0, rd_data_nb[p*32 +: 32]}, {32'h0, e_dnb});
        chk($sformatf("rnd%0d nbbsy%0d", c, p), {63'h0, rd_busy_nb[p]},          {63'h0, e_bnb});
      end
      chk($sformatf("rnd%0d busy_vec", c),    {32'h0, busy_vec},    {32'h0, bref});
      chk($sformatf("rnd%0d busy_vec_nb", c), {32'h0, busy_vec_nb}, {32'h0, bref});
      for (int k = 0; k < 2; k++) begin
        if (we[k] && wa[k] != 5'd0) begin
          mref[wa[k]] = wd[k];
          bref[wa[k]] = 1'b0;
        end
      end
      if (ce && ca != 5'd0) bref[ca] = 1'b1;
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
